// File: rtl/collision_matrix_detector_if.sv
// Bus between the layer drawers / game FSM and collision_matrix_detector.
// master: the side that drives drawing requests and acks reports.
// slave : the detector itself.
interface collision_matrix_detector_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CNT_W      = 8
);
    localparam int unsigned NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

    logic                        startOfFrame;
    logic [NUM_LAYERS-1:0]       drawing_request;
    logic [NUM_PAIRS-1:0]        pair_mask;
    logic                        frame_ack;
    logic                        collision;
    logic [NUM_PAIRS-1:0]        collision_pairs;
    logic [NUM_PAIRS-1:0]        collision_pulse;
    logic [NUM_PAIRS-1:0]        frame_hits;
    logic                        frame_valid;
    logic                        frame_overrun;
    logic [NUM_PAIRS*CNT_W-1:0]  frame_counts;

    modport master (
        output startOfFrame,
        output drawing_request,
        output pair_mask,
        output frame_ack,
        input  collision,
        input  collision_pairs,
        input  collision_pulse,
        input  frame_hits,
        input  frame_valid,
        input  frame_overrun,
        input  frame_counts
    );

    modport slave (
        input  startOfFrame,
        input  drawing_request,
        input  pair_mask,
        input  frame_ack,
        output collision,
        output collision_pairs,
        output collision_pulse,
        output frame_hits,
        output frame_valid,
        output frame_overrun,
        output frame_counts
    );
endinterface

// File: rtl/collision_matrix_detector.sv
// Per-layer-pair pixel collision detector with per-frame sticky hit reports.
// Every enabled pair (i<j, enumerated i-major) that draws the same pixel is
// flagged one cycle later; hits are accumulated per frame and handed to game
// logic at each start-of-frame through a valid/ack handshake.
// Optional per-pair saturating pixel counters: define COLLISION_COUNT_EN.
// Without it frame_counts is tied to zero and no counters exist.
module collision_matrix_detector #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        resetN,
    collision_matrix_detector_if.slave  bus
);
    localparam int unsigned NUM_PAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [NUM_PAIRS-1:0]   hit;

    logic                   collision_q;
    logic [NUM_PAIRS-1:0]   collision_pairs_q;
    logic [NUM_PAIRS-1:0]   pulse_q;
    logic [NUM_PAIRS-1:0]   pulse_d;
    logic [NUM_PAIRS-1:0]   sticky_q;
    logic [NUM_PAIRS-1:0]   sticky_d;
    logic [NUM_PAIRS-1:0]   frame_hits_q;
    logic [NUM_PAIRS-1:0]   frame_hits_d;
    logic                   frame_valid_q;
    logic                   frame_valid_d;
    logic                   frame_overrun_q;
    logic                   frame_overrun_d;

    // Pair k = (i,j): both layers draw this pixel and the pair is enabled.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_col
            localparam int unsigned K = gi * (2 * NUM_LAYERS - gi - 1) / 2 + (gj - gi - 1);
            assign hit[K] = bus.drawing_request[gi] & bus.drawing_request[gj] & bus.pair_mask[K];
        end
    end

    // Frame tracking state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the first SOF after reset opens the first (unreported) frame.
    always_comb begin
        state_d = state_q;
        if ((state_q == WAIT_SOF) && bus.startOfFrame) begin
            state_d = ACTIVE;
        end
    end

    // Sticky accumulation, first-hit pulses and frame report handshake.
    always_comb begin
        sticky_d        = sticky_q;
        pulse_d         = '0;
        frame_hits_d    = frame_hits_q;
        frame_valid_d   = frame_valid_q;
        frame_overrun_d = frame_overrun_q;

        if (bus.frame_ack && frame_valid_q) begin
            frame_valid_d   = 1'b0;
            frame_overrun_d = 1'b0;
        end

        unique case (state_q)
            WAIT_SOF: begin
                sticky_d = '0;
                if (bus.startOfFrame) begin
                    sticky_d = hit;
                end
            end
            ACTIVE: begin
                if (bus.startOfFrame) begin
                    // SOF pixel belongs to the new frame, so it starts fresh.
                    frame_hits_d    = sticky_q;
                    frame_valid_d   = 1'b1;
                    frame_overrun_d = frame_valid_q & ~bus.frame_ack;
                    sticky_d        = hit;
                    pulse_d         = hit;
                end else begin
                    sticky_d = sticky_q | hit;
                    pulse_d  = hit & ~sticky_q;
                end
            end
            default: begin
                sticky_d = '0;
            end
        endcase
    end

    // Output and sticky registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_q       <= 1'b0;
            collision_pairs_q <= '0;
            pulse_q           <= '0;
            sticky_q          <= '0;
            frame_hits_q      <= '0;
            frame_valid_q     <= 1'b0;
            frame_overrun_q   <= 1'b0;
        end else begin
            collision_q       <= |hit;
            collision_pairs_q <= hit;
            pulse_q           <= pulse_d;
            sticky_q          <= sticky_d;
            frame_hits_q      <= frame_hits_d;
            frame_valid_q     <= frame_valid_d;
            frame_overrun_q   <= frame_overrun_d;
        end
    end

    assign bus.collision       = collision_q;
    assign bus.collision_pairs = collision_pairs_q;
    assign bus.collision_pulse = pulse_q;
    assign bus.frame_hits      = frame_hits_q;
    assign bus.frame_valid     = frame_valid_q;
    assign bus.frame_overrun   = frame_overrun_q;

`ifdef COLLISION_COUNT_EN
    for (genvar gk = 0; gk < NUM_PAIRS; gk++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] rpt_q;
        logic [CNT_W-1:0] rpt_d;

        // Saturating per-frame pixel count; SOF snapshots it and restarts.
        always_comb begin
            cnt_d = cnt_q;
            rpt_d = rpt_q;
            if (bus.startOfFrame) begin
                cnt_d = CNT_W'(hit[gk]);
                if (state_q == ACTIVE) begin
                    rpt_d = cnt_q;
                end
            end else if (state_q == WAIT_SOF) begin
                cnt_d = '0;
            end else if (hit[gk] && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Counter and reported-count registers.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                cnt_q <= '0;
                rpt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                rpt_q <= rpt_d;
            end
        end

        assign bus.frame_counts[gk*CNT_W +: CNT_W] = rpt_q;
    end
`else
    assign bus.frame_counts = {(NUM_PAIRS*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_collision_matrix_detector.sv
// Scoreboard bench: the stimulus process runs a frame-level reference model
// and queues the expected outputs; a monitor pops and compares every cycle.
module tb_collision_matrix_detector;
    localparam int unsigned NL = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned NP = NL * (NL - 1) / 2;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    collision_matrix_detector_if #(.NUM_LAYERS(NL), .CNT_W(CW)) bus ();

    collision_matrix_detector #(.NUM_LAYERS(NL), .CNT_W(CW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        bit              coll;
        bit [NP-1:0]     pairs;
        bit [NP-1:0]     pulse;
        bit [NP-1:0]     hits;
        bit              valid;
        bit              over;
        bit [NP*CW-1:0]  counts;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Pair table: which two layers make up pair k.
    int pa[NP];
    int pb[NP];

    // Reference model state.
    bit          m_in_frame;
    bit [NP-1:0] m_seen;
    int          m_cnt[NP];
    bit [NP-1:0] r_hits;
    bit          r_valid;
    bit          r_over;
    int          r_cnt[NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One pixel: drive inputs at negedge, advance the model, queue expectation.
    task automatic cyc(input bit rst, input bit sof, input bit [NL-1:0] dr,
                       input bit [NP-1:0] mask, input bit ack);
        exp_t        e;
        bit [NP-1:0] hit;
        int          sat;
        @(negedge clk);
        resetN              = rst;
        bus.startOfFrame    = sof;
        bus.drawing_request = dr;
        bus.pair_mask       = mask;
        bus.frame_ack       = ack;
        e   = '{default: '0};
        sat = (1 << CW) - 1;
        if (!rst) begin
            m_in_frame = 1'b0;
            m_seen     = '0;
            r_hits     = '0;
            r_valid    = 1'b0;
            r_over     = 1'b0;
            for (int k = 0; k < NP; k++) begin
                m_cnt[k] = 0;
                r_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < NP; k++) begin
                hit[k] = dr[pa[k]] & dr[pb[k]] & mask[k];
            end
            e.pairs = hit;
            e.coll  = |hit;
            if (m_in_frame) begin
                e.pulse = sof ? hit : (hit & ~m_seen);
            end
            if (m_in_frame && sof) begin
                r_over  = r_valid && !ack;
                r_valid = 1'b1;
                r_hits  = m_seen;
                for (int k = 0; k < NP; k++) r_cnt[k] = m_cnt[k];
            end else if (ack && r_valid) begin
                r_valid = 1'b0;
                r_over  = 1'b0;
            end
            if (sof) begin
                m_in_frame = 1'b1;
                m_seen     = hit;
                for (int k = 0; k < NP; k++) m_cnt[k] = int'(hit[k]);
            end else if (m_in_frame) begin
                m_seen = m_seen | hit;
                for (int k = 0; k < NP; k++) m_cnt[k] += int'(hit[k]);
            end
            e.hits  = r_hits;
            e.valid = r_valid;
            e.over  = r_over;
`ifdef COLLISION_COUNT_EN
            for (int k = 0; k < NP; k++) begin
                e.counts[k*CW +: CW] = CW'((r_cnt[k] > sat) ? sat : r_cnt[k]);
            end
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit [NL-1:0] dr, input bit [NP-1:0] mask);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, dr, mask, 1'b0);
    endtask

    // Monitor: compare registered outputs shortly after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("collision",       64'(bus.collision),       64'(e.coll));
                chk("collision_pairs", 64'(bus.collision_pairs), 64'(e.pairs));
                chk("collision_pulse", 64'(bus.collision_pulse), 64'(e.pulse));
                chk("frame_hits",      64'(bus.frame_hits),      64'(e.hits));
                chk("frame_valid",     64'(bus.frame_valid),     64'(e.valid));
                chk("frame_overrun",   64'(bus.frame_overrun),   64'(e.over));
                chk("frame_counts",    64'(bus.frame_counts),    64'(e.counts));
            end
        end
    end

    initial begin
        int          k;
        bit [NL-1:0] dr;
        bit [NP-1:0] mask;
        k = 0;
        for (int a = 0; a < NL; a++) begin
            for (int b = a + 1; b < NL; b++) begin
                pa[k] = a;
                pb[k] = b;
                k++;
            end
        end
        resetN              = 1'b0;
        bus.startOfFrame    = 1'b0;
        bus.drawing_request = '0;
        bus.pair_mask       = '0;
        bus.frame_ack       = 1'b0;

        // Reset, then reset mid-frame with layers 0,1 colliding.
        repeat (3) cyc(1'b0, 1'b0, 4'b0000, 6'b111111, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(4, 4'b0011, 6'b111111);
        repeat (3) cyc(1'b0, 1'b0, 4'b0011, 6'b111111, 1'b0);
        idle(2, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(3, 4'b0000, 6'b111111);

        // Pair 1 for 5 pixels, pair 4 for 1 pixel, then report.
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(2, 4'b0000, 6'b111111);
        idle(5, 4'b0101, 6'b111111);
        idle(1, 4'b1010, 6'b111111);
        idle(3, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(2, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b0, 4'b0000, 6'b111111, 1'b1);

        // Pair 0 masked for a whole frame.
        cyc(1'b1, 1'b1, 4'b0011, 6'b111110, 1'b0);
        idle(10, 4'b0011, 6'b111110);
        cyc(1'b1, 1'b1, 4'b0011, 6'b111110, 1'b0);
        idle(2, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b0, 4'b0000, 6'b111111, 1'b1);

        // Overrun: two SOFs without ack, then ack.
        idle(3, 4'b0110, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(3, 4'b1100, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(2, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b0, 4'b0000, 6'b111111, 1'b1);
        idle(2, 4'b0000, 6'b111111);

        // SOF with ack, pair 2 hit on the SOF pixel.
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(2, 4'b0011, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        idle(1, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b1, 4'b1001, 6'b111111, 1'b1);
        idle(3, 4'b0000, 6'b111111);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b1);
        idle(2, 4'b0000, 6'b111111);

        // Saturation: pair 5 for 20 pixels; back-to-back SOFs.
        idle(20, 4'b1100, 6'b111111);
        cyc(1'b1, 1'b1, 4'b1100, 6'b111111, 1'b1);
        cyc(1'b1, 1'b1, 4'b1111, 6'b111111, 1'b0);
        cyc(1'b1, 1'b1, 4'b0000, 6'b111111, 1'b0);
        cyc(1'b1, 1'b0, 4'b0000, 6'b111111, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NL; b++) dr[b] = ($urandom_range(0, 9) < 4);
            mask = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
            cyc(($urandom_range(0, 399) != 0), ($urandom_range(0, 11) == 0), dr, mask,
                ($urandom_range(0, 2) == 0));
        end
        idle(2, 4'b0000, 6'b111111);

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        if (total < 12) begin
            total++;
            bad++;
            $display("FAIL count: only %0d comparisons, expected at least 12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/collision_matrix_detector.md
Name: collision_matrix_detector

Overview:
Parametrised successor to the two-input pixel collision detector. Takes one drawing-request bit per graphics layer, detects every enabled layer pair drawing the same pixel, and latches per-frame sticky hit flags. At each start-of-frame it reports the previous frame's hits to game logic through a valid/ack handshake. Sits between the layer drawers/mux and the game-control FSM, in the clk pixel domain.

Parameters:
NUM_LAYERS, 4, number of drawing-request inputs; legal range 2..8.
CNT_W, 8, width of each per-pair pixel counter; used only with the optional feature.
NUM_PAIRS, NUM_LAYERS*(NUM_LAYERS-1)/2, derived localparam, not overridable.

Ports:
clk  in  1  pixel clock.
resetN  in  1  asynchronous, active-low reset.
startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
drawing_request  in  NUM_LAYERS  bit i = layer i draws the current pixel.
pair_mask  in  NUM_PAIRS  bit k = 1 enables detection for pair k.
frame_ack  in  1  consumer acknowledge of frame report.
collision  out  1  registered OR of collision_pairs.
collision_pairs  out  NUM_PAIRS  registered per-pair pixel hit.
collision_pulse  out  NUM_PAIRS  one-cycle pulse on the first hit of pair k in the current frame.
frame_hits  out  NUM_PAIRS  previous frame's sticky hits, held while frame_valid.
frame_valid  out  1  frame report available.
frame_overrun  out  1  a report was overwritten before it was acked.
frame_counts  out  NUM_PAIRS*CNT_W  per-pair pixel counts of previous frame; pair k at bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset is asynchronous, active-low, on clk; clock is clk. On reset every output = 0, all sticky flags and counters = 0, FSM = WAIT_SOF.
- Pair index: pairs (i,j) with i<j, enumerated i-major. For NUM_LAYERS=4: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- hit[k] (combinational) = drawing_request[i] & drawing_request[j] & pair_mask[k].
- collision_pairs <= hit every cycle; collision <= |hit. Latency 1 cycle, independent of FSM state. A mask change takes effect on the same-cycle hit.
- FSM has two states:
  - WAIT_SOF: sticky is held at 0, collision_pulse = 0, no reports. On startOfFrame -> ACTIVE, and sticky <= hit (the SOF pixel belongs to the new frame).
  - ACTIVE: sticky[k] <= sticky[k] | hit[k]. collision_pulse[k] <= hit[k] & ~sticky[k], so at most one pulse per pair per frame, aligned with the first collision_pairs[k] assertion.
- startOfFrame while ACTIVE:
  - frame_hits <= sticky; frame_valid <= 1; sticky <= hit.
  - collision_pulse[k] <= hit[k], because the new frame starts fresh.
- Handshake:
  - frame_ack while frame_valid=1 -> frame_valid <= 0 next cycle and frame_overrun <= 0.
  - frame_hits is held until the next SOF. frame_ack while frame_valid=0 is ignored.
- Overrun: SOF while frame_valid=1 and no frame_ack -> report overwritten, frame_valid stays 1, frame_overrun <= 1. frame_overrun stays 1 until acked.
- SOF and frame_ack in the same cycle: the old report counts as consumed. The new report is loaded, frame_valid stays 1, frame_overrun <= 0.
- Consecutive-cycle SOF pulses are legal. Each one reports a 1-cycle frame.
- Reset asserted mid-frame returns the block to WAIT_SOF. The first frame after reset is never reported.

Optional Feature:
Macro: COLLISION_COUNT_EN.
- Defined:
  - Per-pair CNT_W-bit saturating counter increments on hit[k] while ACTIVE, saturating at 2^CNT_W-1.
  - On SOF, frame_counts slice k <= counter (or counter+1 if hit[k] in the same cycle is still in the old frame? No: the SOF pixel goes to the new frame). So frame_counts slice k <= counter, and counter <= hit[k].
  - frame_counts is held like frame_hits.
- Undefined: no counters are synthesised and frame_counts is tied to 0. Port list is identical in both cases.

Test Plan:
1. Reset mid-frame: layers 0,1 colliding, resetN low 3 cycles -> all outputs 0, FSM WAIT_SOF. Next SOF gives no frame_valid.
2. N=4, mask=6'b111111. Between two SOFs, layers 0 and 2 overlap for 5 pixels, then layers 1 and 3 overlap for 1 pixel -> collision_pulse[1] fires once, collision_pulse[4] fires once. At the second SOF, frame_hits=6'b010010 and frame_valid=1. With COLLISION_COUNT_EN, count slice1=5 and slice4=1.
3. Mask: pair_mask=6'b111110, layers 0 and 1 overlap for a full frame -> collision stays 0, no pulse, frame_hits[0]=0.
4. Overrun: two SOFs with no ack -> frame_overrun=1 and frame_hits = the second frame's hits. Then ack -> frame_valid=0 and frame_overrun=0 next cycle.
5. SOF and ack in the same cycle, with a pair 2 hit on the SOF pixel -> frame_valid stays 1, frame_overrun=0, collision_pulse[2] fires, and the new sticky[2]=1 is reported at the following SOF.
6. Saturation (CNT_W=4, COLLISION_COUNT_EN): pair 5 overlaps for 20 pixels in one frame -> frame_counts slice5=15.
